mem_ctrl: RTL

Memory controller with wait states, placed downstream of the MAR/MDR pair of the Mini SRC datapath. It accepts one read or write request per transaction and runs a fixed-latency access against an internal word-addressed RAM. It returns read data on `Mdatain` for the MDR and signals completion with a one-cycle `Done` pulse that the control unit uses to leave its memory-wait step.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/ram_sp.sv | 40 ++++
 rtl/mem_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the memory controller.
//               Holds the controller state encoding, the data width, the
//               maximum number of wait states and the width of the wait
//               counter that holds them.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int DATA_W          = 32;
  localparam int MAX_WAIT_CYCLES = 15;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_sp.sv
// ============================================================================
// Module      : ram_sp
// Description : Single-port synchronous RAM with a registered read port.
//               Every rising edge captures mem[addr] into rdata. When we is
//               high, wdata is also written to mem[addr]. A read at the same
//               edge as a write returns the old word. Contents have no reset.
// Ports       : clk   - clock
//               we    - write enable
//               addr  - word address, ADDR_W bits
//               wdata - write data, DATA_W bits
//               rdata - registered read data, DATA_W bits
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module      : mem_ctrl
// Description : Memory controller for the Mini SRC MAR/MDR pair. It accepts
//               one read or write at a time and inserts WAIT_CYCLES wait
//               states. It then performs the access on an internal ram_sp
//               and pulses Done for one cycle. Throughput is one
//               transaction per WAIT_CYCLES + 2 cycles.
// Config      : MEM_ADDR_CHK_EN - when defined, a nonzero Address[31:ADDR_W]
//               at acceptance suppresses the RAM write. It also forces
//               Mdatain to 0 and pulses Err with Done. When undefined, upper
//               address bits alias and Err is 0.
// Ports       : Clock     - clock, rising edge
//               Clear     - asynchronous active-high reset
//               Address   - word address from MAR (32)
//               WriteData - store data from MDR (32)
//               Read      - read request, sampled in IDLE only
//               Write     - write request, sampled in IDLE only
//               Mdatain   - read data to MDR, held until next read (32)
//               Done      - one-cycle completion pulse
//               Busy      - transaction in progress
//               Err       - address-range error, pulses with Done
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Done,
  output logic              Busy,
  output logic              Err
);

  // Out-of-range settings saturate rather than wrap in the 4-bit counter.
  localparam int WAIT_EFF = (WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               op_wr_q;
  logic               addr_err_q;
  logic [DATA_W-1:0]  mdata_q;
  logic               done_q;
  logic               err_q;

  logic               accept;
  logic               range_err;
  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_we;
  logic [DATA_W-1:0]  ram_rdata;

`ifdef MEM_ADDR_CHK_EN
  assign range_err = |Address[31:ADDR_W];
`else
  logic unused_upper_addr;
  assign unused_upper_addr = |Address[31:ADDR_W];
  assign range_err         = 1'b0;
`endif

  assign accept = (state == IDLE) && (Read || Write);

  // In IDLE the RAM reads the live address. With zero wait states, the
  // word for a read accepted at this edge is then ready in ACCESS. Once a
  // request is accepted, the latched address drives the RAM.
  assign ram_addr = (state == IDLE) ? Address[ADDR_W-1:0] : addr_q;
  assign ram_we   = (state == ACCESS) && op_wr_q && !addr_err_q;

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (Clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (WAIT_EFF > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_wr_q    <= 1'b0;
      addr_err_q <= 1'b0;
      mdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        cnt        <= CNT_W'(WAIT_EFF);
        addr_q     <= Address[ADDR_W-1:0];
        wdata_q    <= WriteData;
        // A simultaneous read and write resolves to the read.
        op_wr_q    <= Write && !Read;
        addr_err_q <= range_err;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end

      done_q <= (state == ACCESS);
      err_q  <= (state == ACCESS) && addr_err_q;

      if ((state == ACCESS) && !op_wr_q) begin
        mdata_q <= addr_err_q ? '0 : ram_rdata;
      end
    end
  end

  assign Mdatain = mdata_q;
  assign Done    = done_q;
  assign Busy    = (state != IDLE);
  assign Err     = err_q;

endmodule

`default_nettype wire
